// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU arbiter: opcode values, status-flag bit
// positions and the controller state encoding.
package alu_ctrl_pkg;

  localparam int OP_OR    = 0;
  localparam int OP_AND   = 1;
  localparam int OP_XOR   = 2;
  localparam int OP_ADD   = 3;
  localparam int OP_SUB   = 4;
  localparam int OP_SHIFT = 5;
  localparam int OP_LAST  = 5;

  localparam int FLG_COUT = 0;
  localparam int FLG_NEG  = 1;
  localparam int FLG_ZERO = 2;
  localparam int FLG_PAR  = 3;
  localparam int FLG_OVF  = 4;
  localparam int FLAGS_W  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } ctrlState_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone requester always wins, and on a tie the
// requester that was not granted last time wins.
module rr_arbiter2 (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       lastGrant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (valid0 && valid1) begin
      grant = lastGrant ? 2'b01 : 2'b10;
    end else begin
      grant = {valid1, valid0};
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters: round-robin grant,
// registered operands, captured result/flags, per-requester response port.
module alu_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  input  logic               req1_valid,
  output logic               req0_ready,
  output logic               req1_ready,
  input  logic [OPW-1:0]     req0_op,
  input  logic [OPW-1:0]     req1_op,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic               rsp0_valid,
  output logic               rsp1_valid,
  input  logic               rsp0_ready,
  input  logic               rsp1_ready,
  output logic [WIDTH-1:0]   rsp_data,
  output logic [FLAGS_W-1:0] rsp_flags,
  output logic               rsp_err,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [OPW-1:0]     alu_op,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_cout,
  input  logic               alu_negative,
  input  logic               alu_zero,
  input  logic               alu_parity,
  input  logic               alu_overflow,
  output logic               busy
);

  ctrlState_t state, nextState;

  logic               lastGrant;
  logic               owner;
  logic [1:0]         arbGrant;
  logic [1:0]         grant;
  logic               rspFire;
  logic [OPW-1:0]     selOp;
  logic [WIDTH-1:0]   selA;
  logic [WIDTH-1:0]   selB;
  logic               selLegal;
  logic [WIDTH-1:0]   aReg;
  logic [WIDTH-1:0]   bReg;
  logic [OPW-1:0]     opReg;
  logic [WIDTH-1:0]   dataReg;
  logic [FLAGS_W-1:0] flagsReg;
  logic               errReg;
  logic [FLAGS_W-1:0] aluFlags;

  rr_arbiter2 u_rrArbiter (
    .valid0    (req0_valid),
    .valid1    (req1_valid),
    .lastGrant (lastGrant),
    .grant     (arbGrant)
  );

  always_comb begin
    selOp    = arbGrant[1] ? req1_op : req0_op;
    selA     = arbGrant[1] ? req1_a  : req0_a;
    selB     = arbGrant[1] ? req1_b  : req0_b;
    selLegal = (selOp <= OPW'(OP_LAST));
  end

  always_comb begin
    aluFlags           = '0;
    aluFlags[FLG_COUT] = alu_cout;
    aluFlags[FLG_NEG]  = alu_negative;
    aluFlags[FLG_ZERO] = alu_zero;
    aluFlags[FLG_PAR]  = alu_parity;
    aluFlags[FLG_OVF]  = alu_overflow;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Illegal opcodes skip EXEC so the ALU never sees them.
  always_comb begin
    nextState = state;
    grant     = 2'b00;
    rspFire   = 1'b0;
    unique case (state)
      IDLE: begin
        grant = arbGrant;
        if (|arbGrant) begin
          nextState = selLegal ? EXEC : RESP;
        end
      end
      EXEC: nextState = RESP;
      RESP: begin
        rspFire = owner ? rsp1_ready : rsp0_ready;
        if (rspFire) begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Pointer resets to 1 so that requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lastGrant <= 1'b1;
      owner     <= 1'b0;
      aReg      <= '0;
      bReg      <= '0;
      opReg     <= '0;
      dataReg   <= '0;
      flagsReg  <= '0;
      errReg    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|grant) begin
            owner <= grant[1];
            if (selLegal) begin
              aReg  <= selA;
              bReg  <= selB;
              opReg <= selOp;
            end else begin
              dataReg  <= '0;
              flagsReg <= '0;
              errReg   <= 1'b1;
            end
          end
        end
        EXEC: begin
          dataReg  <= alu_result;
          flagsReg <= aluFlags;
          errReg   <= 1'b0;
        end
        RESP: begin
          if (rspFire) begin
            lastGrant <= owner;
          end
        end
        default: ;
      endcase
    end
  end

  // Ready is masked by reset so every output reads 0 while reset is held.
  assign req0_ready = grant[0] & ~rst;
  assign req1_ready = grant[1] & ~rst;
  assign rsp0_valid = (state == RESP) && !owner;
  assign rsp1_valid = (state == RESP) && owner;
  assign rsp_data   = dataReg;
  assign rsp_flags  = flagsReg;
  assign rsp_err    = errReg;
  assign alu_a      = aReg;
  assign alu_b      = bReg;
  assign alu_op     = opReg;
  assign busy       = (state != IDLE);

endmodule
